// File: rtl/parallel2serial_tx.sv
// parallel2serial_tx: serialises (para1, para2) word pairs onto srl in continuous 4-slot frames.
// Latency: a word taken at a slot-3 edge bypasses to srl at once; otherwise it waits in hold, at most 4 cycles.
// Backpressure: in_ready = !hold_full (registered), so the source may be stalled for up to one frame.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   in_valid/in_ready source handshake; a word is taken on any edge with both high
//   para1, para2      2-bit parallel words forming one 4-bit frame
//   srl               serial data, one bit per clock, frame bit 0 first
//   slot              index (0..3) of the bit currently on srl
//   sof               high while slot == 0
//   data_active       frame on srl carries source data (0 = idle frame)
//   idle_cnt          saturating count of inserted idle frames

module parallel2serial_tx #(
    parameter logic [3:0]  IDLE_WORD = 4'b0000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       para1,
    input  logic [1:0]       para2,
    output logic             srl,
    output logic [1:0]       slot,
    output logic             sof,
    output logic             data_active,
    output logic [CNT_W-1:0] idle_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Frame state: slot counter, the word being shifted out and its registered bit.
    logic [1:0]       slot_q, slot_d;
    logic [3:0]       frame_q, frame_d;
    logic             srl_q, srl_d;
    logic             sof_q, sof_d;
    logic             data_active_q, data_active_d;

    // One-entry holding buffer between the source and frame timing.
    logic [3:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic [3:0]       in_word;
    logic             boundary;
    logic             accept;

    // Interleave the two words so each receiver lane sees one bit of each
    // word per half-frame: slot 0/2 carry para2, slot 1/3 carry para1.
    assign in_word  = {para1[1], para2[1], para1[0], para2[0]};
    assign boundary = (slot_q == 2'd3);
    assign accept   = in_valid && !hold_full_q;

    always_comb begin
        slot_d        = slot_q + 2'd1;
        frame_d       = frame_q;
        srl_d         = srl_q;
        data_active_d = data_active_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        idle_cnt_d    = idle_cnt_q;

        if (boundary) begin
            // Next frame source, highest priority first: held word,
            // bypassed input word, idle filler.
            if (hold_full_q) begin
                frame_d       = hold_q;
                hold_full_d   = 1'b0;
                data_active_d = 1'b1;
            end else if (in_valid) begin
                frame_d       = in_word;
                data_active_d = 1'b1;
            end else begin
                frame_d       = IDLE_WORD;
                data_active_d = 1'b0;
                if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            srl_d = frame_d[0];
        end else begin
            // Mid-frame accepts park in hold; the frame register is untouched
            // until the boundary so the word in flight is never disturbed.
            if (accept) begin
                hold_d      = in_word;
                hold_full_d = 1'b1;
            end
            srl_d = frame_q[slot_d];
        end

        sof_d = (slot_d == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= 2'd0;
            frame_q       <= IDLE_WORD;
            srl_q         <= IDLE_WORD[0];
            sof_q         <= 1'b1;
            data_active_q <= 1'b0;
            hold_q        <= 4'd0;
            hold_full_q   <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            slot_q        <= slot_d;
            frame_q       <= frame_d;
            srl_q         <= srl_d;
            sof_q         <= sof_d;
            data_active_q <= data_active_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign srl         = srl_q;
    assign slot        = slot_q;
    assign sof         = sof_q;
    assign data_active = data_active_q;
    assign idle_cnt    = idle_cnt_q;

endmodule

// File: tb/tb_parallel2serial_tx.sv
// tb_parallel2serial_tx: self-checking bench for parallel2serial_tx.
// Latency: n/a (testbench).
// Backpressure: source honours in_ready; a loopback receiver checks every frame.

module tb_parallel2serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] para1 = 2'b00;
    logic [1:0] para2 = 2'b00;
    logic       srl;
    logic [1:0] slot;
    logic       sof;
    logic       data_active;
    logic [7:0] idle_cnt;

    // Second instance with a 2-bit idle counter, used only for saturation.
    logic       rst2 = 1'b1;
    logic       in_valid2 = 1'b0;
    logic [1:0] para1_2 = 2'b00;
    logic [1:0] para2_2 = 2'b00;
    logic       in_ready2;
    logic       srl2;
    logic [1:0] slot2;
    logic       sof2;
    logic       data_active2;
    logic [1:0] idle_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sbq[$];  // expected {para1, para2} in transmit order

    always #5 clk = ~clk;

    parallel2serial_tx #(.IDLE_WORD(4'b0000), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .para1(para1), .para2(para2), .srl(srl), .slot(slot), .sof(sof),
        .data_active(data_active), .idle_cnt(idle_cnt)
    );

    parallel2serial_tx #(.IDLE_WORD(4'b0000), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .para1(para1_2), .para2(para2_2), .srl(srl2), .slot(slot2), .sof(sof2),
        .data_active(data_active2), .idle_cnt(idle_cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       vld;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       e_srl;
        logic       e_rdy;
        logic       e_da;
        logic [7:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [1:0] p1, input logic [1:0] p2,
                                input logic e_srl, input logic e_rdy, input logic e_da,
                                input logic [7:0] e_cnt);
        vec_t v;
        v.vld = vld; v.p1 = p1; v.p2 = p2;
        v.e_srl = e_srl; v.e_rdy = e_rdy; v.e_da = e_da; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Loopback receiver: rebuilds each frame from srl and compares it with
    // the scoreboard (data frames) or the idle word (idle frames).
    initial begin
        logic [3:0] mb;
        logic       m_ok;
        logic       m_da;
        logic [3:0] exp_w;
        mb = 4'd0; m_ok = 1'b0; m_da = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ok = 1'b0;
            end else begin
                if (slot == 2'd0) begin
                    m_ok = 1'b1;
                    m_da = data_active;
                end
                if (m_ok) begin
                    mb[slot] = srl;
                    if (slot == 2'd3) begin
                        if (m_da) begin
                            if (sbq.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL loopback_unexpected_word actual=%0h expected=none", mb);
                            end else begin
                                exp_w = sbq.pop_front();
                                chk("loopback_word", {28'd0, mb[3], mb[1], mb[2], mb[0]}, {28'd0, exp_w});
                            end
                        end else begin
                            chk("idle_frame_bits", {28'd0, mb}, 32'h0);
                        end
                        m_ok = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t       vecs[28];
    logic [3:0] sw[8];
    int         acc_t[8];

    initial begin
        int i;
        int cyc;
        int n;

        // Table: idle 0..14, bypass word at slot 3 (k=15), mid-frame word at
        // slot 1 (k=17) which goes through hold, then idle again.
        for (int k = 0; k < 28; k++) begin
            vecs[k] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0,
                         (k < 4) ? 8'd0 : (k < 8) ? 8'd1 : (k < 12) ? 8'd2 : (k < 24) ? 8'd3 : 8'd4);
        end
        vecs[15] = mk(1'b1, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 8'd3);
        vecs[16] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 8'd3);
        vecs[17] = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 8'd3);
        vecs[18] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'd3);
        vecs[19] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 8'd3);
        vecs[20] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 8'd3);
        vecs[21] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 8'd3);
        vecs[22] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 8'd3);
        vecs[23] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 8'd3);

        sw[0] = 4'b1001; sw[1] = 4'b0110; sw[2] = 4'b1111; sw[3] = 4'b0001;
        sw[4] = 4'b1000; sw[5] = 4'b0100; sw[6] = 4'b0010; sw[7] = 4'b1101;

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_srl", {31'd0, srl}, 32'd0);
        chk("rst_slot", {30'd0, slot}, 32'd0);
        chk("rst_sof", {31'd0, sof}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_data_active", {31'd0, data_active}, 32'd0);
        chk("rst_idle_cnt", {24'd0, idle_cnt}, 32'd0);

        @(posedge clk);
        #2 rst = 1'b0;

        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_slot", k), {30'd0, slot}, k % 4);
            chk($sformatf("v%0d_sof", k), {31'd0, sof}, ((k % 4) == 0) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_srl", k), {31'd0, srl}, {31'd0, vecs[k].e_srl});
            chk($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, {31'd0, vecs[k].e_rdy});
            chk($sformatf("v%0d_data_active", k), {31'd0, data_active}, {31'd0, vecs[k].e_da});
            chk($sformatf("v%0d_idle_cnt", k), {24'd0, idle_cnt}, {24'd0, vecs[k].e_cnt});
            in_valid = vecs[k].vld;
            para1    = vecs[k].p1;
            para2    = vecs[k].p2;
            if (vecs[k].vld && in_ready) sbq.push_back({vecs[k].p1, vecs[k].p2});
        end

        // Back-to-back stream starting at slot 0: one accept every 4 cycles,
        // no idle frames until the stream has drained.
        @(negedge clk);
        chk("stream_start_slot", {30'd0, slot}, 32'd0);
        chk("stream_start_idle_cnt", {24'd0, idle_cnt}, 32'd5);
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 100) begin
            in_valid = 1'b1;
            {para1, para2} = sw[i];
            if (in_ready) begin
                sbq.push_back(sw[i]);
                acc_t[i] = cyc;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_all_accepted", i, 32'd8);
        for (int j = 1; j < 8; j++) begin
            chk($sformatf("stream_accept_gap%0d", j), acc_t[j] - acc_t[j-1], 32'd4);
        end
        n = 0;
        #1;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stream_drained", sbq.size(), 32'd0);
        chk("stream_idle_cnt_unchanged", {24'd0, idle_cnt}, 32'd5);

        // Reset at slot 2 of a data frame with hold full.
        n = 0;
        while (slot != 2'd3 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("align_slot3", {30'd0, slot}, 32'd3);
        in_valid = 1'b1;
        para1 = 2'b01;
        para2 = 2'b10;
        if (in_ready) sbq.push_back(4'b0110);
        @(negedge clk);
        para1 = 2'b11;
        para2 = 2'b11;
        if (in_ready) sbq.push_back(4'b1111);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_slot", {30'd0, slot}, 32'd2);
        chk("mid_hold_full", {31'd0, in_ready}, 32'd0);
        chk("mid_data_active", {31'd0, data_active}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_srl", {31'd0, srl}, 32'd0);
        chk("arst_slot", {30'd0, slot}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_sof", {31'd0, sof}, 32'd1);
        chk("arst_data_active", {31'd0, data_active}, 32'd0);
        chk("arst_idle_cnt", {24'd0, idle_cnt}, 32'd0);
        sbq.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_data_active", k), {31'd0, data_active}, 32'd0);
            chk($sformatf("post_rst%0d_srl", k), {31'd0, srl}, 32'd0);
        end

        // Saturation of a 2-bit idle counter over 24 idle cycles.
        @(posedge clk);
        #2 rst2 = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k == 0)  chk("sat_cnt_k0", {30'd0, idle_cnt2}, 32'd0);
            if (k == 8)  chk("sat_cnt_k8", {30'd0, idle_cnt2}, 32'd2);
            if (k == 16) chk("sat_cnt_k16", {30'd0, idle_cnt2}, 32'd3);
            if (k == 24) chk("sat_cnt_k24", {30'd0, idle_cnt2}, 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parallel2serial_tx.md
Name: parallel2serial_tx

Overview:
- Transmit-side counterpart of the 4-slot serial-to-parallel receiver.
- Accepts a pair of 2-bit parallel words (para1, para2) through a valid/ready handshake and serialises them onto a single bit line `srl`, one bit per clk.
- Frames are continuous and fixed at 4 slots, with slot alignment established by reset, so a receiver reset in the same domain stays frame-locked.
- When no data is pending, an idle frame is inserted. A one-entry holding buffer decouples the source from frame timing.

Parameters:
- IDLE_WORD, 4'b0000, frame sent when no data is available; bit k is transmitted in slot k.
- CNT_W, 8, width of the saturating idle-frame counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a word on para1/para2.
- in_ready  output  1  holding buffer can accept a word (= !hold_full, registered state only).
- para1  input  2  parallel word 1.
- para2  input  2  parallel word 2.
- srl  output  1  serial data, registered.
- slot  output  2  index (0..3) of the bit currently on srl.
- sof  output  1  high while slot==0.
- data_active  output  1  current frame carries source data (0 = idle frame).
- idle_cnt  output  CNT_W  saturating count of idle frames inserted.

Behaviour:
- Slot mapping for frame word F[3:0]:
  - F[0]=para2[0], F[1]=para1[0], F[2]=para2[1], F[3]=para1[1].
  - Serial order is F[0] first (slot 0) through F[3] (slot 3).
- Reset (async; all outputs registered):
  - slot=0, frame reg=IDLE_WORD, srl=IDLE_WORD[0], sof=1, data_active=0.
  - hold_full=0, so in_ready=1; idle_cnt=0.
  - The frame in flight at reset release is an idle frame and is not counted in idle_cnt.
- Handshake: a word is accepted on any edge with in_valid && in_ready. in_ready depends only on hold_full, with no combinational path from in_valid.
- Non-boundary edge (slot 0..2):
  - slot<=slot+1; srl<=frame[slot+1].
  - An accepted word is written into hold; hold_full<=1.
- Boundary edge (slot==3):
  - slot<=0; the next-frame source is chosen by priority:
    1. hold_full: frame<=hold, hold_full<=0 (or remains 1 if a new word is accepted the same edge; impossible since in_ready=0).
    2. !hold_full && in_valid: bypass, frame<=input word, hold stays empty.
    3. Otherwise: frame<=IDLE_WORD, idle_cnt<=idle_cnt+1, saturating at all-ones.
  - srl<=new frame bit 0; data_active<=1 for cases 1 and 2, 0 for case 3.
- Latency:
  - Word accepted at a boundary edge (bypass): bit 0 appears on srl immediately after that edge.
  - Otherwise the word waits in hold until the next boundary; worst case 4 cycles from accept to first bit.
  - The receiver presents the word after the slot-3 capture edge.
- Throughput: one word per 4 cycles sustained.
  - in_ready deasserts after a non-boundary accept and reasserts after the next boundary edge.
- Hold contents are never overwritten while full. Data is never dropped or duplicated.
- Reset mid-frame: the partial frame is abandoned, hold is discarded, and framing restarts at slot 0 with IDLE_WORD.
- slot wraps 3->0 and free-runs regardless of traffic.

Test Plan:
- Reset then idle for 12 cycles, IDLE_WORD=4'b0000 -> srl=0 throughout; slot cycles 0,1,2,3; sof every 4th cycle; idle_cnt=3; data_active=0.
- Present para1=2'b10, para2=2'b01 with in_valid on the slot-3 cycle -> next 4 srl bits 1,0,0,1; data_active=1 for that frame; hold stays empty; in_ready stays 1.
- Present para1=2'b11, para2=2'b00 at slot 1 -> in_ready drops next cycle, then the frame after the boundary carries bits 0,1,0,1; in_ready returns to 1 at slot 0.
- Back-to-back stream of 8 words with in_valid held high -> one word accepted per 4 cycles; srl matches the mapping for every word; no idle frames inserted (idle_cnt unchanged); a loopback receiver reproduces all 8 pairs in order.
- Assert rst at slot 2 of a data frame with hold full -> srl=IDLE_WORD[0], slot=0, in_ready=1 immediately; the held word is never transmitted.
- Set CNT_W=2 and idle for 24 cycles -> idle_cnt saturates at 3 and does not wrap.
